// File: rtl/lsu_mem_sequencer_if.sv
// Data-memory bus between the load/store sequencer and the memory system.
// Single outstanding beat, req/ack handshake, 32-bit data lanes.
interface lsu_mem_sequencer_if #(
  parameter int ADDR_W = 32
) ();
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [31:0]       bus_wdata;
  logic              bus_ack;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/lsu_mem_sequencer.sv
// Load/store sequencer: turns one decoded memory op into one or two word
// beats on the data bus, then reports a single done/err pulse with the
// extended load result and writeback control. All outputs are registered.
module lsu_mem_sequencer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  access_size,
  input  logic        is_unsigned,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [63:0] rdata,
  output logic        wb_en,
  output logic [4:0]  rd_out,
  lsu_mem_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    FIN   = 2'd3
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_DBL  = 2'b11;

  // Counter is sized for TIMEOUT_CYCLES-1; a zero parameter disables timeout.
  localparam int                CNT_W   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit                TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Byte enables of the first beat for a given size and byte offset.
  function automatic logic [3:0] beat_be(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: beat_be = 4'b0001 << a;
      SZ_HALF: beat_be = 4'b0011 << {a[1], 1'b0};
      default: beat_be = 4'b1111;
    endcase
  endfunction

  // Store data replicated across all lanes so the enabled lanes carry it.
  function automatic logic [31:0] beat_wdata(input logic [1:0] size, input logic [31:0] w);
    case (size)
      SZ_BYTE: beat_wdata = {4{w[7:0]}};
      SZ_HALF: beat_wdata = {2{w[15:0]}};
      default: beat_wdata = w;
    endcase
  endfunction

  // Natural alignment check on the effective address.
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] a);
    case (size)
      SZ_HALF: misaligned = a[0];
      SZ_WORD: misaligned = (a[1:0] != 2'b00);
      SZ_DBL:  misaligned = (a[2:0] != 3'b000);
      default: misaligned = 1'b0;
    endcase
  endfunction

  // Lane selection and sign/zero extension for sub-doubleword loads.
  function automatic logic [63:0] extract_load(input logic [1:0] size, input logic uns,
                                               input logic [1:0] a, input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{a, 3'b000} +: 8];
    h = word[{a[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: extract_load = uns ? {56'd0, b} : {{56{b[7]}}, b};
      SZ_HALF: extract_load = uns ? {48'd0, h} : {{48{h[15]}}, h};
      SZ_WORD: extract_load = uns ? {32'd0, word} : {{32{word[31]}}, word};
      default: extract_load = {32'd0, word};
    endcase
  endfunction

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [63:0]       rdata_q, rdata_d;
  logic              wb_en_q, wb_en_d;
  logic [4:0]        rd_q, rd_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]        bus_be_q, bus_be_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        lane_q, lane_d;
  logic              store_q, store_d;
  logic [31:0]       wdata_hi_q, wdata_hi_d;
  logic [31:0]       lo_word_q, lo_word_d;
  logic              release_s;
  logic              timeout_s;
  logic              unused_addr_s;

  // Address bits above the bus width never reach the bus.
  assign unused_addr_s = ^addr[63:ADDR_W];

  assign timeout_s = TO_EN && (cnt_q == TO_LAST);

  // Next-state, bus beat and completion logic.
  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    rdata_d     = 64'd0;
    wb_en_d     = 1'b0;
    rd_d        = rd_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    cnt_d       = cnt_q;
    size_d      = size_q;
    uns_d       = uns_q;
    lane_d      = lane_q;
    store_d     = store_q;
    wdata_hi_d  = wdata_hi_q;
    lo_word_d   = lo_word_q;
    release_s   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && (mem_read ^ mem_write)) begin
          size_d     = access_size;
          uns_d      = is_unsigned;
          lane_d     = addr[1:0];
          store_d    = mem_write;
          wdata_hi_d = wdata[63:32];
          rd_d       = rd_in;
          cnt_d      = {CNT_W{1'b0}};
          if (misaligned(access_size, addr[2:0])) begin
            state_d = FIN;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d     = BEAT0;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_write;
            bus_addr_d  = {addr[ADDR_W-1:2], 2'b00};
            bus_be_d    = beat_be(access_size, addr[1:0]);
            bus_wdata_d = beat_wdata(access_size, wdata[31:0]);
          end
        end else begin
          state_d = IDLE;
        end
      end

      BEAT0: begin
        if (bus.bus_ack) begin
          if (size_q == SZ_DBL) begin
            // Second beat follows immediately; bus_req stays high.
            state_d     = BEAT1;
            lo_word_d   = bus.bus_rdata;
            bus_addr_d  = bus_addr_q + ADDR_W'(4);
            bus_be_d    = 4'b1111;
            bus_wdata_d = wdata_hi_q;
            cnt_d       = {CNT_W{1'b0}};
          end else begin
            state_d   = FIN;
            done_d    = 1'b1;
            release_s = 1'b1;
            if (!store_q) begin
              rdata_d = extract_load(size_q, uns_q, lane_q, bus.bus_rdata);
              wb_en_d = 1'b1;
            end else begin
              rdata_d = 64'd0;
              wb_en_d = 1'b0;
            end
          end
        end else if (timeout_s) begin
          state_d   = FIN;
          done_d    = 1'b1;
          err_d     = 1'b1;
          release_s = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      BEAT1: begin
        if (bus.bus_ack) begin
          state_d   = FIN;
          done_d    = 1'b1;
          release_s = 1'b1;
          if (!store_q) begin
            rdata_d = {bus.bus_rdata, lo_word_q};
            wb_en_d = 1'b1;
          end else begin
            rdata_d = 64'd0;
            wb_en_d = 1'b0;
          end
        end else if (timeout_s) begin
          // The low word of a double store has already been written.
          state_d   = FIN;
          done_d    = 1'b1;
          err_d     = 1'b1;
          release_s = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        release_s = 1'b1;
      end
    endcase

    if (release_s) begin
      bus_req_d   = 1'b0;
      bus_we_d    = 1'b0;
      bus_addr_d  = {ADDR_W{1'b0}};
      bus_be_d    = 4'b0000;
      bus_wdata_d = 32'd0;
    end else begin
      bus_req_d   = bus_req_d;
    end

    busy_d = (state_d == BEAT0) || (state_d == BEAT1);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 64'd0;
      wb_en_q     <= 1'b0;
      rd_q        <= 5'd0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= {ADDR_W{1'b0}};
      bus_be_q    <= 4'b0000;
      bus_wdata_q <= 32'd0;
      cnt_q       <= {CNT_W{1'b0}};
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      lane_q      <= 2'b00;
      store_q     <= 1'b0;
      wdata_hi_q  <= 32'd0;
      lo_word_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      wb_en_q     <= wb_en_d;
      rd_q        <= rd_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      lane_q      <= lane_d;
      store_q     <= store_d;
      wdata_hi_q  <= wdata_hi_d;
      lo_word_q   <= lo_word_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign rdata         = rdata_q;
  assign wb_en         = wb_en_q;
  assign rd_out        = rd_q;
  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_be    = bus_be_q;
  assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Self-checking bench for lsu_mem_sequencer. A driver builds, per op, the
// cycle-by-cycle picture the outputs must show (from address arithmetic,
// ack delays and a memory image) and a separate compare process checks the
// DUT against it every cycle. Directed ops pin the model with literals.
module tb_lsu_mem_sequencer;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n, start, mem_read, mem_write, is_unsigned;
  logic [1:0]  access_size;
  logic [63:0] addr, wdata;
  logic [4:0]  rd_in;
  logic        busy, done, err, wb_en;
  logic [63:0] rdata;
  logic [4:0]  rd_out;

  always #5 clk = ~clk;

  lsu_mem_sequencer_if #(.ADDR_W(32)) bus_if ();

  lsu_mem_sequencer #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_read(mem_read), .mem_write(mem_write),
    .access_size(access_size), .is_unsigned(is_unsigned), .addr(addr), .wdata(wdata),
    .rd_in(rd_in), .busy(busy), .done(done), .err(err), .rdata(rdata), .wb_en(wb_en),
    .rd_out(rd_out), .bus(bus_if)
  );

  typedef struct {
    logic        req, we, busy, done, err, wb, ack;
    logic [31:0] baddr, bwd, ack_data;
    logic [3:0]  be;
    logic [63:0] rdata;
    logic [4:0]  rd;
  } rec_t;

  rec_t        exp_r;
  rec_t        rec_q[$];
  bit          chk_en = 1'b0;
  int          n_cmp = 0, n_fail = 0;
  logic [31:0] mem [logic [31:0]];

  int          cap_req_cycles, cap_done_cnt;
  logic [31:0] cap_first_addr, cap_last_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we, cap_err, cap_wb;
  logic [63:0] cap_rdata;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic rec_t idle_rec();
    rec_t r;
    r = '{default: '0};
    return r;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Expected load result from the spec's extraction rules, plain arithmetic.
  function automatic logic [63:0] model_load(input logic [1:0] sz, input logic uns,
                                             input logic [31:0] a, input logic [31:0] lo,
                                             input logic [31:0] hi);
    logic [63:0] v;
    int lane;
    lane = int'(a % 32'd4);
    case (sz)
      2'd0: begin
        v = ({32'd0, lo} >> (8 * lane)) & 64'hFF;
        if (!uns && v >= 64'd128) v = v - 64'd256;
      end
      2'd1: begin
        v = ({32'd0, lo} >> (8 * lane)) & 64'hFFFF;
        if (!uns && v >= 64'h8000) v = v - 64'h1_0000;
      end
      2'd2: begin
        v = {32'd0, lo};
        if (!uns && v >= 64'h8000_0000) v = v - 64'h1_0000_0000;
      end
      default: v = {32'd0, hi} * 64'h1_0000_0000 + {32'd0, lo};
    endcase
    return v;
  endfunction

  // Builds the expected per-cycle outputs following the accept cycle.
  task automatic build_timeline(input logic rd_, input logic wr_, input logic [1:0] sz,
                                input logic uns, input logic [63:0] a64, input logic [63:0] w,
                                input logic [4:0] rd, input int d0, input int d1);
    rec_t r, fin;
    logic [31:0] a, baddr, lo, hi;
    int lane, nb, n, dly;
    bit ok;
    rec_q.delete();
    if (rd_ == wr_) return;
    a    = a64[31:0];
    lane = int'(a % 32'd4);
    fin  = idle_rec();
    fin.done = 1'b1;
    fin.rd   = rd;
    if ((a % (32'd1 << sz)) != 32'd0) begin
      fin.err = 1'b1;
      rec_q.push_back(fin);
      return;
    end
    nb = (sz == 2'd3) ? 2 : 1;
    lo = 32'd0; hi = 32'd0; ok = 1'b1;
    for (int b = 0; b < nb; b++) begin
      baddr = a - (a % 32'd4) + 32'(4 * b);
      dly   = (b == 0) ? d0 : d1;
      n     = (dly < TO) ? dly + 1 : TO;
      for (int k = 0; k < n; k++) begin
        r = idle_rec();
        r.req = 1'b1; r.busy = 1'b1; r.we = wr_; r.baddr = baddr;
        if (b == 1) begin
          r.be = 4'hF; r.bwd = w[63:32];
        end else if (sz == 2'd0) begin
          r.be = 4'(1 << lane); r.bwd = {24'd0, w[7:0]} * 32'h0101_0101;
        end else if (sz == 2'd1) begin
          r.be = 4'(3 << lane); r.bwd = {16'd0, w[15:0]} * 32'h0001_0001;
        end else begin
          r.be = 4'hF; r.bwd = w[31:0];
        end
        if (dly < TO && k == n - 1) begin
          r.ack = 1'b1; r.ack_data = mem_rd(baddr);
        end
        rec_q.push_back(r);
      end
      if (dly >= TO) begin
        ok = 1'b0;
        break;
      end
      if (b == 0) lo = mem_rd(baddr); else hi = mem_rd(baddr);
    end
    fin.err = !ok;
    if (ok && rd_) begin
      fin.rdata = model_load(sz, uns, a, lo, hi);
      fin.wb    = 1'b1;
    end
    rec_q.push_back(fin);
  endtask

  // Advance one cycle: set the expectation for it and drive bus responses.
  task automatic step(input rec_t r);
    @(posedge clk);
    #1;
    exp_r = r;
    bus_if.bus_ack   = r.req ? r.ack : 1'($urandom_range(0, 1));
    bus_if.bus_rdata = (r.req && r.ack) ? r.ack_data : $urandom;
  endtask

  task automatic reset_caps();
    cap_req_cycles = 0; cap_done_cnt = 0;
  endtask

  task automatic idle_cycles(input int n, input bit invalid);
    for (int i = 0; i < n; i++) begin
      step(idle_rec());
      start     = invalid;
      mem_read  = 1'($urandom_range(0, 1));
      mem_write = mem_read;
      addr      = {$urandom, $urandom};
    end
  endtask

  task automatic run_op(input logic rd_, input logic wr_, input logic [1:0] sz, input logic uns,
                        input logic [63:0] a, input logic [63:0] w, input logic [4:0] rd,
                        input int d0, input int d1, input int rst_at);
    rec_t q[$];
    build_timeline(rd_, wr_, sz, uns, a, w, rd, d0, d1);
    q = rec_q;
    step(idle_rec());
    reset_caps();
    start = 1'b1; mem_read = rd_; mem_write = wr_; access_size = sz;
    is_unsigned = uns; addr = a; wdata = w; rd_in = rd;
    for (int k = 0; k < q.size(); k++) begin
      step(q[k]);
      if (k == rst_at) begin
        start = 1'b0; rst_n = 1'b0; bus_if.bus_ack = 1'b0;
        step(idle_rec());
        rst_n = 1'b1;
        return;
      end else if ($urandom_range(0, 3) == 0) begin
        // Issue attempts while busy or in the completion cycle must be ignored.
        start = 1'b1; mem_read = 1'($urandom_range(0, 1)); mem_write = ~mem_read;
        access_size = 2'($urandom); addr = {$urandom, $urandom}; rd_in = 5'($urandom);
        wdata = {$urandom, $urandom}; is_unsigned = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
    end
  endtask

  function automatic int pick_delay();
    return ($urandom_range(0, 9) == 0) ? int'($urandom_range(TO, TO + 2)) : int'($urandom_range(0, 3));
  endfunction

  // Per-cycle comparison of DUT outputs against the expected picture.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        cmp("bus_req", bus_if.bus_req, exp_r.req);
        cmp("busy", busy, exp_r.busy);
        cmp("done", done, exp_r.done);
        cmp("wb_en", wb_en, exp_r.wb);
        if (exp_r.req) begin
          cmp("bus_we", bus_if.bus_we, exp_r.we);
          cmp("bus_addr", bus_if.bus_addr, exp_r.baddr);
          cmp("bus_be", bus_if.bus_be, exp_r.be);
          cmp("bus_wdata", bus_if.bus_wdata, exp_r.bwd);
        end
        if (exp_r.done) begin
          cmp("err", err, exp_r.err);
          cmp("rdata", rdata, exp_r.rdata);
          cmp("rd_out", rd_out, exp_r.rd);
        end
        if (bus_if.bus_req) begin
          if (cap_req_cycles == 0) cap_first_addr = bus_if.bus_addr;
          cap_last_addr = bus_if.bus_addr; cap_be = bus_if.bus_be;
          cap_wdata = bus_if.bus_wdata; cap_we = bus_if.bus_we;
          cap_req_cycles++;
        end
        if (done) begin
          cap_done_cnt++; cap_rdata = rdata; cap_err = err; cap_wb = wb_en;
        end
      end
    end
  end

  // Stimulus: reset, directed ops with literal checks, then random ops.
  initial begin
    rst_n = 1'b0; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0; access_size = 2'b00;
    is_unsigned = 1'b0; addr = 64'd0; wdata = 64'd0; rd_in = 5'd0;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'd0;
    exp_r = idle_rec();
    reset_caps();
    repeat (3) @(posedge clk);
    #1;
    cmp("rst_busy", busy, 64'd0);       cmp("rst_done", done, 64'd0);
    cmp("rst_err", err, 64'd0);         cmp("rst_rdata", rdata, 64'd0);
    cmp("rst_wb_en", wb_en, 64'd0);     cmp("rst_rd_out", rd_out, 64'd0);
    cmp("rst_req", bus_if.bus_req, 64'd0); cmp("rst_we", bus_if.bus_we, 64'd0);
    cmp("rst_addr", bus_if.bus_addr, 64'd0); cmp("rst_be", bus_if.bus_be, 64'd0);
    cmp("rst_wdata", bus_if.bus_wdata, 64'd0);
    chk_en = 1'b1;
    rst_n  = 1'b1;

    // lw, two wait cycles
    mem[32'h1000] = 32'h8000_0001;
    run_op(1'b1, 1'b0, 2'b10, 1'b0, 64'h1000, 64'd0, 5'd7, 2, 0, -1);
    idle_cycles(1, 1'b0);
    cmp("lw_req_cycles", cap_req_cycles, 64'd3);
    cmp("lw_be", cap_be, 64'hF);
    cmp("lw_rdata", cap_rdata, 64'hFFFF_FFFF_8000_0001);
    cmp("lw_wb", cap_wb, 64'd1);

    // lbu / lb from the top lane
    mem[32'h1000] = 32'hA512_3456;
    run_op(1'b1, 1'b0, 2'b00, 1'b1, 64'h1003, 64'd0, 5'd3, 0, 0, -1);
    idle_cycles(1, 1'b0);
    cmp("lbu_be", cap_be, 64'h8);
    cmp("lbu_rdata", cap_rdata, 64'h0000_0000_0000_00A5);
    run_op(1'b1, 1'b0, 2'b00, 1'b0, 64'h1003, 64'd0, 5'd4, 1, 0, -1);
    idle_cycles(1, 1'b0);
    cmp("lb_rdata", cap_rdata, 64'hFFFF_FFFF_FFFF_FFA5);

    // sh to upper half
    run_op(1'b0, 1'b1, 2'b01, 1'b0, 64'h2002, 64'h1234_5678_9ABC_BEEF, 5'd9, 1, 0, -1);
    idle_cycles(1, 1'b0);
    cmp("sh_we", cap_we, 64'd1);
    cmp("sh_be", cap_be, 64'hC);
    cmp("sh_wdata", cap_wdata, 64'hBEEF_BEEF);
    cmp("sh_done_cnt", cap_done_cnt, 64'd1);
    cmp("sh_wb", cap_wb, 64'd0);

    // ld, two beats
    mem[32'h3000] = 32'h1111_2222;
    mem[32'h3004] = 32'h3333_4444;
    run_op(1'b1, 1'b0, 2'b11, 1'b0, 64'h3000, 64'd0, 5'd11, 0, 1, -1);
    idle_cycles(1, 1'b0);
    cmp("ld_addr0", cap_first_addr, 64'h3000);
    cmp("ld_addr1", cap_last_addr, 64'h3004);
    cmp("ld_rdata", cap_rdata, 64'h3333_4444_1111_2222);

    // misaligned lw: no bus activity
    run_op(1'b1, 1'b0, 2'b10, 1'b0, 64'h1002, 64'd0, 5'd5, 0, 0, -1);
    idle_cycles(1, 1'b0);
    cmp("mis_req_cycles", cap_req_cycles, 64'd0);
    cmp("mis_err", cap_err, 64'd1);
    cmp("mis_done_cnt", cap_done_cnt, 64'd1);

    // timeout on a word load
    run_op(1'b1, 1'b0, 2'b10, 1'b0, 64'h1000, 64'd0, 5'd6, 50, 0, -1);
    idle_cycles(1, 1'b0);
    cmp("to_req_cycles", cap_req_cycles, 64'd4);
    cmp("to_err", cap_err, 64'd1);
    cmp("to_wb", cap_wb, 64'd0);

    // double load timing out on its second beat
    run_op(1'b1, 1'b0, 2'b11, 1'b0, 64'h3000, 64'd0, 5'd12, 0, 9, -1);
    idle_cycles(1, 1'b0);
    cmp("ld_to_err", cap_err, 64'd1);
    cmp("ld_to_wb", cap_wb, 64'd0);

    // start with neither or both direction bits
    reset_caps();
    idle_cycles(6, 1'b1);
    cmp("invalid_done_cnt", cap_done_cnt, 64'd0);

    // reset during the second beat of sd
    run_op(1'b0, 1'b1, 2'b11, 1'b0, 64'h4000, 64'hCAFE_F00D_1234_5678, 5'd13, 1, 3, 2);
    idle_cycles(1, 1'b0);
    cmp("rst_mid_done_cnt", cap_done_cnt, 64'd0);
    run_op(1'b1, 1'b0, 2'b10, 1'b1, 64'h3004, 64'd0, 5'd14, 0, 0, -1);
    idle_cycles(1, 1'b0);
    cmp("post_rst_rdata", cap_rdata, 64'h0000_0000_3333_4444);

    // random ops
    for (int i = 0; i < 300; i++) begin
      logic        rd_, uns;
      logic [1:0]  sz;
      logic [63:0] a;
      rd_ = 1'($urandom_range(0, 1));
      sz  = 2'($urandom);
      uns = 1'($urandom_range(0, 1));
      a   = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
      run_op(rd_, ~rd_, sz, uns, a, {$urandom, $urandom}, 5'($urandom),
             pick_delay(), pick_delay(), -1);
      idle_cycles(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end
    idle_cycles(2, 1'b0);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
